dsc_mul_engine: RTL and testbench

DSC_MUL_ENGINE -- requirements
Module: dsc_mul_engine

---
 rtl/dsc_pkg.sv | 15 +
 rtl/dsc_unary_gen.sv | 12 +
 rtl/dsc_mul_engine.sv | 113 +++++++++++
 tb/tb_dsc_mul_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the stream counter and of the ones accumulator.
   function automatic int stream_width(input int num_inputs, input int data_width);
      return num_inputs * data_width;
   endfunction

endpackage

// File: rtl/dsc_unary_gen.sv
// Per-operand unary stream bit: high while the counter digit is below the operand.
module dsc_unary_gen #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0] digit_i,
   input  logic [DATA_WIDTH-1:0] operand_i,
   output logic                  bit_o
);

   assign bit_o = (digit_i < operand_i);

endmodule

// File: rtl/dsc_mul_engine.sv
// Clock-division deterministic unary multiplier: counts the cycles in which all streams are 1.
// Optional macro DSC_EARLY_TERM_EN: a zero operand skips RUN and completes immediately with 0.
module dsc_mul_engine
   import dsc_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2
) (
   input  logic                                   gclk,
   input  logic                                   rst,
   input  logic                                   en,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  bin_data_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0]       bin_data_out,
   output logic                                   op_finished
);

   localparam int CW = stream_width(NUM_INPUTS, DATA_WIDTH);

   state_e                                state_q, state_d;
   logic [CW-1:0]                         cnt_q, cnt_d;
   logic [CW-1:0]                         acc_q, acc_d;
   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops_q, ops_d;
   logic                                  fin_q, fin_d;
   logic [NUM_INPUTS-1:0]                 stream_bits;

   // Each operand walks its own digit slice of the counter, so together they sweep every tuple once.
   generate
      for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unary
         dsc_unary_gen #(
            .DATA_WIDTH(DATA_WIDTH)
         ) u_unary_gen (
            .digit_i  (cnt_q[gi*DATA_WIDTH +: DATA_WIDTH]),
            .operand_i(ops_q[gi]),
            .bit_o    (stream_bits[gi])
         );
      end
   endgenerate

`ifdef DSC_EARLY_TERM_EN
   logic any_zero;
   always_comb begin
      any_zero = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (bin_data_in[i] == '0) any_zero = 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ops_d   = ops_q;
      fin_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               ops_d   = bin_data_in;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
`ifdef DSC_EARLY_TERM_EN
               if (any_zero) begin
                  state_d = DONE;
                  fin_d   = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            if (en) begin
               acc_d = acc_q + CW'(&stream_bits);
               cnt_d = cnt_q + CW'(1);
               // The all-ones digit tuple is the last one; the wrap to zero never feeds the accumulator.
               if (&cnt_q) begin
                  state_d = DONE;
                  fin_d   = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ops_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ops_q   <= ops_d;
         fin_q   <= fin_d;
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign op_finished  = fin_q;
   assign bin_data_out = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_dsc_mul_engine.sv
// Bench for dsc_mul_engine (DATA_WIDTH=3, NUM_INPUTS=2): directed scenarios plus random operations.
module tb_dsc_mul_engine;

   localparam int DW  = 3;
   localparam int NI  = 2;
   localparam int RUN_LEN = 1 << (DW * NI);
`ifdef DSC_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic                    gclk = 1'b0;
   logic                    rst = 1'b0;
   logic                    en = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [NI-1:0][DW-1:0]   bin_data_in = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [NI*DW-1:0]        bin_data_out;
   logic                    op_finished;

   int n_cmp = 0;
   int n_bad = 0;

   // Abstract model state: 0 = waiting for operands, 1 = computing, 2 = result held.
   int m_phase = 0;
   int m_left  = 0;
   int m_res   = 0;
   bit m_fin   = 1'b0;

   dsc_mul_engine #(
      .DATA_WIDTH(DW),
      .NUM_INPUTS(NI)
   ) dut (
      .gclk        (gclk),
      .rst         (rst),
      .en          (en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .bin_data_in (bin_data_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .bin_data_out(bin_data_out),
      .op_finished (op_finished)
   );

   always #5 gclk = ~gclk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: product by plain multiplication, latency by counting enabled cycles.
   initial begin
      forever begin
         @(posedge gclk);
         if (!rst) begin
            m_phase = 0;
            m_fin   = 1'b0;
         end else begin
            m_fin = 1'b0;
            case (m_phase)
               0: if (in_valid) begin
                     m_res = int'(bin_data_in[0]) * int'(bin_data_in[1]);
                     if (EARLY && (bin_data_in[0] == 0 || bin_data_in[1] == 0)) begin
                        m_phase = 2;
                        m_fin   = 1'b1;
                     end else begin
                        m_phase = 1;
                        m_left  = RUN_LEN;
                     end
                  end
               1: if (en) begin
                     m_left--;
                     if (m_left == 0) begin
                        m_phase = 2;
                        m_fin   = 1'b1;
                     end
                  end
               default: if (out_ready) m_phase = 0;
            endcase
         end
         #1;
         check("model_in_ready", int'(in_ready), int'(m_phase == 0));
         check("model_out_valid", int'(out_valid), int'(m_phase == 2));
         check("model_op_finished", int'(op_finished), int'(m_fin));
         if (m_phase == 2 || !rst) check("model_data_out", int'(bin_data_out), (m_phase == 2) ? m_res : 0);
      end
   end

   // en_mode: 0 = always on, 1 = toggle every cycle, 2 = random. inject: iteration at which a stray in_valid is pulsed (-1 none).
   task automatic run_op(input int a, input int b, input int en_mode, input int hold, input int inject,
                         output int lat, output int res, output int fins, output int stable);
      lat = 0; fins = 0; stable = 0; res = -1;
      @(negedge gclk);
      in_valid       = 1'b1;
      bin_data_in[0] = DW'(a);
      bin_data_in[1] = DW'(b);
      en             = 1'b1;
      out_ready      = (hold == 0);
      for (int c = 0; c < 2000; c++) begin
         @(posedge gclk); #1;
         lat++;
         if (op_finished) fins++;
         if (out_valid) break;
         @(negedge gclk);
         in_valid = (c == inject);
         if (c == inject) begin
            bin_data_in[0] = 3'd7;
            bin_data_in[1] = 3'd7;
         end
         if (en_mode == 1) en = ~en;
         else if (en_mode == 2) en = 1'($urandom_range(0, 1));
      end
      check("result_seen", int'(out_valid), 1);
      res = int'(bin_data_out);
      if (out_valid && !in_ready) stable++;
      for (int h = 1; h < hold; h++) begin
         @(posedge gclk); #1;
         if (op_finished) fins++;
         if (out_valid && !in_ready && int'(bin_data_out) == res) stable++;
      end
      @(negedge gclk);
      out_ready = 1'b1;
      en        = 1'b1;
      in_valid  = 1'b0;
      @(posedge gclk); #1;
      if (op_finished) fins++;
      check("back_to_idle_ready", int'(in_ready), 1);
      check("back_to_idle_valid", int'(out_valid), 0);
   endtask

   initial begin
      int lat, res, fins, stable, ov;
      #12;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_op_finished", int'(op_finished), 0);
      check("reset_data_out", int'(bin_data_out), 0);
      @(negedge gclk);
      rst = 1'b1;

      run_op(5, 6, 0, 0, -1, lat, res, fins, stable);
      $display("op 5x6: result=%0d latency=%0d finished_pulses=%0d", res, lat, fins);
      check("s1_result", res, 30);
      check("s1_latency", lat, RUN_LEN + 1);
      check("s1_pulses", fins, 1);

      run_op(7, 7, 1, 0, -1, lat, res, fins, stable);
      $display("op 7x7 toggled en: result=%0d latency=%0d", res, lat);
      check("s2_result", res, 49);
      check("s2_latency", lat, 2 * RUN_LEN + 1);

      run_op(3, 4, 0, 10, -1, lat, res, fins, stable);
      $display("op 3x4 held: result=%0d stable_cycles=%0d", res, stable);
      check("s3_result", res, 12);
      check("s3_stable", stable, 10);
      check("s3_pulses", fins, 1);

      @(negedge gclk);
      in_valid = 1'b1; bin_data_in[0] = 3'd6; bin_data_in[1] = 3'd7; en = 1'b1;
      @(posedge gclk);
      @(negedge gclk);
      in_valid = 1'b0;
      repeat (20) @(posedge gclk);
      #2 rst = 1'b0;
      #1;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_op_finished", int'(op_finished), 0);
      @(negedge gclk);
      @(negedge gclk);
      rst = 1'b1;
      fins = 0; ov = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge gclk); #1;
         if (op_finished) fins++;
         if (out_valid) ov++;
      end
      $display("abort: pulses=%0d valid_cycles=%0d after reset", fins, ov);
      check("abort_no_pulse", fins, 0);
      check("abort_no_result", ov, 0);
      run_op(2, 3, 0, 0, -1, lat, res, fins, stable);
      $display("op 2x3 after abort: result=%0d", res);
      check("s4_result", res, 6);

      run_op(0, 5, 0, 0, -1, lat, res, fins, stable);
      $display("op 0x5: result=%0d latency=%0d", res, lat);
      check("s5_result", res, 0);
      check("s5_latency", lat, EARLY ? 1 : RUN_LEN + 1);

      run_op(2, 2, 0, 0, 5, lat, res, fins, stable);
      $display("op 2x2 with stray in_valid: result=%0d", res);
      check("s6_result", res, 4);
      check("s6_latency", lat, RUN_LEN + 1);

      for (int k = 0; k < 8; k++) begin
         int a, b;
         a = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         run_op(a, b, 2, int'($urandom_range(0, 3)), -1, lat, res, fins, stable);
         $display("op %0dx%0d random en: result=%0d latency=%0d", a, b, res, lat);
         check("rand_result", res, a * b);
         check("rand_pulses", fins, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
